// File: rtl/ll_seizure_detector_pkg.sv
// Shared definitions for the line-length detection datapath: stage widths and
// detector state encodings.
package ll_seizure_detector_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int MID_WIDTH    = 17;
  localparam int OUTPUT_WIDTH = 25;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_SEIZURE   = 2'd2,
    ST_RELEASING = 2'd3
  } det_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ll_seizure_detector_if.sv
// Feature/threshold input bus and detector status outputs between ll_module
// side (master) and ll_seizure_detector (slave).
interface ll_seizure_detector_if #(
  parameter int FEAT_WIDTH = 25
);
  logic                         en;
  logic signed [FEAT_WIDTH-1:0] din;
  logic                         din_valid;
  logic        [FEAT_WIDTH-1:0] thr_on;
  logic        [FEAT_WIDTH-1:0] thr_off;
  logic                         seizure;
  logic                         onset_pulse;
  logic                         offset_pulse;
  logic                         dout_valid;

  modport master (
    output en, din, din_valid, thr_on, thr_off,
    input  seizure, onset_pulse, offset_pulse, dout_valid
  );

  modport slave (
    input  en, din, din_valid, thr_on, thr_off,
    output seizure, onset_pulse, offset_pulse, dout_valid
  );
endinterface

// File: rtl/ll_seizure_detector_run_counter.sv
// ll_run_counter: saturating persistence counter with clear / load-one /
// increment controls and a flag that the next increment reaches i_term.
module ll_run_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_next_term
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_p1;

  assign w_cnt_p1    = r_cnt + ONE_C;
  assign o_next_term = (w_cnt_p1 == i_term);

  // Count register; increments stop at MAX_VAL instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= ONE_C;
    end else if (i_inc && (r_cnt < MAX_C)) begin
      r_cnt <= w_cnt_p1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/ll_seizure_detector.sv
// Hysteresis/persistence seizure detector on the line-length feature stream.
// Optional LL_DETECT_EVENT_CNT_EN adds a saturating onset event counter output.
module ll_seizure_detector
  import ll_seizure_detector_pkg::*;
#(
  parameter int FEAT_WIDTH = OUTPUT_WIDTH,
  parameter int ON_COUNT   = 4,
  parameter int OFF_COUNT  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ll_seizure_detector_if.slave  bus
`ifdef LL_DETECT_EVENT_CNT_EN
  ,
  output logic [15:0]           o_event_cnt
`endif
);

  localparam int CNT_MAX = max_int(ON_COUNT, OFF_COUNT);

  det_state_e            r_state;
  det_state_e            w_next_state;
  logic                  r_seizure;
  logic                  r_onset;
  logic                  r_offset;
  logic                  r_dout_valid;

  logic                  w_consume;
  logic [FEAT_WIDTH-1:0] w_feat;
  logic                  w_ge_on;
  logic                  w_lt_off;
  logic                  w_onset;
  logic                  w_offset;
  logic                  w_clr;
  logic                  w_load1;
  logic                  w_inc;
  logic                  w_next_term;
  logic [CNT_WIDTH-1:0]  w_term;

  assign w_consume = bus.en && bus.din_valid;
  // Negative features carry no energy; clamp to zero before unsigned compare.
  assign w_feat    = bus.din[FEAT_WIDTH-1] ? '0 : $unsigned(bus.din);
  assign w_ge_on   = (w_feat >= bus.thr_on);
  assign w_lt_off  = (w_feat <  bus.thr_off);
  assign w_term    = (r_state == ST_ARMING) ? CNT_WIDTH'(ON_COUNT) : CNT_WIDTH'(OFF_COUNT);

  ll_run_counter #(
    .WIDTH   (CNT_WIDTH),
    .MAX_VAL (CNT_MAX)
  ) u_run_counter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_load1     (w_load1),
    .i_inc       (w_inc),
    .i_term      (w_term),
    .o_next_term (w_next_term)
  );

  // Next-state, counter controls and pulse decode for the consumed sample.
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_load1      = 1'b0;
    w_inc        = 1'b0;
    w_onset      = 1'b0;
    w_offset     = 1'b0;
    if (w_consume) begin
      case (r_state)
        ST_IDLE: begin
          if (w_ge_on) begin
            w_load1 = 1'b1;
            if (ON_COUNT == 1) begin
              w_next_state = ST_SEIZURE;
              w_onset      = 1'b1;
            end else begin
              w_next_state = ST_ARMING;
            end
          end else begin
            w_clr = 1'b1;
          end
        end
        ST_ARMING: begin
          if (w_ge_on) begin
            if (w_next_term) begin
              w_next_state = ST_SEIZURE;
              w_onset      = 1'b1;
              w_clr        = 1'b1;
            end else begin
              w_inc = 1'b1;
            end
          end else begin
            w_next_state = ST_IDLE;
            w_clr        = 1'b1;
          end
        end
        ST_SEIZURE: begin
          if (w_lt_off) begin
            w_load1 = 1'b1;
            if (OFF_COUNT == 1) begin
              w_next_state = ST_IDLE;
              w_offset     = 1'b1;
            end else begin
              w_next_state = ST_RELEASING;
            end
          end else begin
            w_next_state = ST_SEIZURE;
          end
        end
        ST_RELEASING: begin
          if (w_lt_off) begin
            if (w_next_term) begin
              w_next_state = ST_IDLE;
              w_offset     = 1'b1;
              w_clr        = 1'b1;
            end else begin
              w_inc = 1'b1;
            end
          end else begin
            w_next_state = ST_SEIZURE;
            w_clr        = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_clr        = 1'b1;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // State and registered outputs; reset aborts any seizure without a pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_seizure    <= 1'b0;
      r_onset      <= 1'b0;
      r_offset     <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_seizure    <= (w_next_state == ST_SEIZURE) || (w_next_state == ST_RELEASING);
      r_onset      <= w_onset;
      r_offset     <= w_offset;
      r_dout_valid <= w_consume;
    end
  end

  assign bus.seizure      = r_seizure;
  assign bus.onset_pulse  = r_onset;
  assign bus.offset_pulse = r_offset;
  assign bus.dout_valid   = r_dout_valid;

`ifdef LL_DETECT_EVENT_CNT_EN
  logic [15:0] r_event_cnt;

  // Onset event count, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_event_cnt <= 16'h0000;
    end else if (w_onset && (r_event_cnt != 16'hFFFF)) begin
      r_event_cnt <= r_event_cnt + 16'h0001;
    end else begin
      r_event_cnt <= r_event_cnt;
    end
  end

  assign o_event_cnt = r_event_cnt;
`endif

endmodule
